// File: rtl/cgra_pad_traffic_checker.sv
// Pad-side traffic checker: drives a stimulus pattern into a CGRA and compares the returned data
// against the stimulus delayed by LATENCY and scaled by SCALE_SHIFT. CGRA_CHECK_STOP_ON_ERROR_EN
// ends the run at the first mismatch.
module cgra_pad_traffic_checker #(
  parameter int unsigned      WIDTH       = 16,
  parameter int unsigned      LATENCY     = 0,
  parameter int unsigned      MAX_CYCLES  = 1000000,
  parameter int unsigned      SCALE_SHIFT = 1,
  parameter logic [WIDTH-1:0] LFSR_TAPS   = WIDTH'(16'hB400)
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             start_in,
  input  logic [1:0]       mode_in,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] data_to_cgra_out,
  input  logic [WIDTH-1:0] data_from_cgra_in,
  output logic             busy_out,
  output logic             done_out,
  output logic             pass_out,
  output logic [15:0]      err_count_out,
  output logic [31:0]      first_err_cycle_out,
  output logic [31:0]      cycle_count_out
);

  typedef enum logic [1:0] {StIdle, StFill, StRun, StDone} state_e;
  typedef enum logic [1:0] {ModeConst, ModeIncr, ModeLfsr} mode_e;

  localparam logic [3:0] LastFill = 4'(LATENCY - 1);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [WIDTH-1:0] stim_q, stim_d, stim_next;
  logic [3:0]       fill_cnt_q, fill_cnt_d;
  logic [15:0]      err_q, err_d;
  logic [31:0]      first_err_q, first_err_d;
  logic [31:0]      cyc_q, cyc_d;
  logic             advance;
  logic             mismatch;
  logic [WIDTH-1:0] dly_out;
  logic [WIDTH-1:0] expected;

  always_comb begin
    stim_next = stim_q;
    unique case (mode_q)
      ModeIncr: stim_next = stim_q + {{(WIDTH-1){1'b0}}, 1'b1};
      ModeLfsr: stim_next = {stim_q[WIDTH-2:0], ^(stim_q & LFSR_TAPS)};
      default:  stim_next = stim_q;
    endcase
  end

  // Reference value: the stimulus as it was LATENCY cycles ago.
  if (LATENCY > 0) begin : g_dly
    logic [WIDTH-1:0] dly_q [LATENCY];
    always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) begin
        for (int i = 0; i < int'(LATENCY); i++) dly_q[i] <= '0;
      end else if (advance) begin
        dly_q[0] <= stim_q;
        for (int i = 1; i < int'(LATENCY); i++) dly_q[i] <= dly_q[i-1];
      end
    end
    assign dly_out = dly_q[LATENCY-1];
  end else begin : g_nodly
    assign dly_out = stim_q;
  end

  assign expected = dly_out << SCALE_SHIFT;
  assign mismatch = (state_q == StRun) && (data_from_cgra_in != expected);

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    stim_d      = stim_q;
    fill_cnt_d  = fill_cnt_q;
    err_d       = err_q;
    first_err_d = first_err_q;
    cyc_d       = cyc_q;
    advance     = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_in) begin
          mode_d      = (mode_in == 2'd3) ? ModeConst : mode_e'(mode_in);
          // An all-zero LFSR would lock up, so a zero seed starts from 1.
          stim_d      = (mode_in == 2'd2 && seed_in == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : seed_in;
          fill_cnt_d  = '0;
          err_d       = '0;
          first_err_d = '1;
          cyc_d       = '0;
          state_d     = (LATENCY == 0) ? StRun : StFill;
        end
      end
      StFill: begin
        advance    = 1'b1;
        stim_d     = stim_next;
        fill_cnt_d = fill_cnt_q + 4'd1;
        if (fill_cnt_q == LastFill) state_d = StRun;
      end
      StRun: begin
        advance = 1'b1;
        stim_d  = stim_next;
        cyc_d   = cyc_q + 32'd1;
        if (mismatch) begin
          if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
          if (first_err_q == '1) first_err_d = cyc_q;
        end
        if (cyc_d == MAX_CYCLES) state_d = StDone;
`ifdef CGRA_CHECK_STOP_ON_ERROR_EN
        if (mismatch) state_d = StDone;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q     <= StIdle;
      mode_q      <= ModeConst;
      stim_q      <= '0;
      fill_cnt_q  <= '0;
      err_q       <= '0;
      first_err_q <= '1;
      cyc_q       <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      stim_q      <= stim_d;
      fill_cnt_q  <= fill_cnt_d;
      err_q       <= err_d;
      first_err_q <= first_err_d;
      cyc_q       <= cyc_d;
    end
  end

  assign data_to_cgra_out    = stim_q;
  assign busy_out            = (state_q == StFill) || (state_q == StRun);
  assign done_out            = (state_q == StDone);
  assign pass_out            = (state_q == StDone) && (err_q == '0);
  assign err_count_out       = err_q;
  assign first_err_cycle_out = first_err_q;
  assign cycle_count_out     = cyc_q;

endmodule

// File: doc/cgra_pad_traffic_checker.md
CGRA_PAD_TRAFFIC_CHECKER -- requirements
Module: cgra_pad_traffic_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 16: pad-side data width in bits, 4..32.
REQ-002 SHALL have parameter LATENCY, default 0: expected CGRA input-to-output latency in cycles, 0..15.
REQ-003 SHALL have parameter MAX_CYCLES, default 1000000: compare-phase length in cycles, 1..2^32-1.
REQ-004 SHALL have parameter SCALE_SHIFT, default 1: expected output is input << SCALE_SHIFT, 0..WIDTH-1.
REQ-005 SHALL have parameter LFSR_TAPS, default 16'hB400: Fibonacci feedback mask, WIDTH bits.
REQ-006 clk_in  input  1  single clock; all state on rising edge.
REQ-007 reset_in  input  1  asynchronous, active-low reset.
REQ-008 start_in  input  1  start pulse; sampled only in IDLE and DONE.
REQ-009 mode_in  input  2  stimulus mode, latched at start: 0 constant, 1 increment, 2 LFSR, 3 treated as 0.
REQ-010 seed_in  input  WIDTH  initial stimulus value, latched at start.
REQ-011 data_to_cgra_out  output  WIDTH  stimulus driven to the CGRA input pad side.
REQ-012 data_from_cgra_in  input  WIDTH  CGRA output pad-side data.
REQ-013 busy_out  output  1  high in FILL and RUN.
REQ-014 done_out  output  1  high in DONE.
REQ-015 pass_out  output  1  high in DONE iff err_count_out == 0.
REQ-016 err_count_out  output  16  mismatch count, saturating at 16'hFFFF.
REQ-017 first_err_cycle_out  output  32  compare-phase cycle index of first mismatch; 32'hFFFFFFFF if none.
REQ-018 cycle_count_out  output  32  compare-phase cycles completed.

Function
REQ-019 SHALL implement FSM IDLE -> FILL -> RUN -> DONE; with LATENCY==0, start goes directly IDLE/DONE -> RUN.
REQ-020 IDLE/DONE with start_in=1 SHALL latch mode_in and seed_in, clear counters, set first_err_cycle_out to all-ones, drive seed on data_to_cgra_out next cycle, and enter FILL (or RUN).
REQ-021 FILL SHALL last exactly LATENCY cycles, advance stimulus every cycle, and perform no compares.
REQ-022 Stimulus SHALL advance once per cycle in FILL/RUN: constant holds; increment adds 1 modulo 2^WIDTH (wraps all-ones -> 0); LFSR shifts left with feedback = XOR(state & LFSR_TAPS) into bit 0.
REQ-023 A zero seed in LFSR mode SHALL be replaced by 1 at latch time.
REQ-024 Expected value SHALL be the stimulus delayed by exactly LATENCY cycles, shifted left by SCALE_SHIFT, truncated to WIDTH bits.
REQ-025 RUN SHALL compare data_from_cgra_in to the expected value each cycle and increment cycle_count_out each cycle.
REQ-026 On mismatch, err_count_out SHALL increment (saturating); on the first mismatch, first_err_cycle_out SHALL latch the current cycle_count_out.
REQ-027 RUN SHALL exit to DONE in the cycle cycle_count_out reaches MAX_CYCLES.
REQ-028 DONE SHALL hold stimulus and all result outputs stable until start_in or reset.
REQ-029 start_in in FILL or RUN SHALL be ignored.
REQ-030 In IDLE, data_to_cgra_out SHALL be 0.

Reset
REQ-031 reset_in low SHALL immediately force IDLE, data_to_cgra_out=0, busy_out=0, done_out=0, pass_out=0, err_count_out=0, cycle_count_out=0, first_err_cycle_out=32'hFFFFFFFF, delay line cleared.
REQ-032 Reset asserted mid-FILL/RUN SHALL abort the run without entering DONE; operation resumes only on a new start_in after reset deasserts.

Configuration
REQ-033 Macro CGRA_CHECK_STOP_ON_ERROR_EN defined: the first mismatch in RUN SHALL move the FSM to DONE on the next edge, with err_count_out=1 and pass_out=0.
REQ-034 Macro undefined: RUN SHALL always complete MAX_CYCLES compares regardless of mismatches.

Verification
REQ-035 WIDTH=16, LATENCY=0, MAX_CYCLES=8, mode 0, seed 3, input tied to 6 -> done after 8 RUN cycles, pass_out=1, err_count_out=0, first_err_cycle_out=FFFFFFFF.
REQ-036 Same, input tied to 7 -> err_count_out=8, first_err_cycle_out=0, pass_out=0 (macro undefined); with macro defined -> err_count_out=1, done after 1 RUN cycle.
REQ-037 LATENCY=3, mode 1, seed 16'hFFFE, input = stimulus<<1 through a 3-stage delay -> pass_out=1; stimulus sequence shows FFFE, FFFF, 0000, 0001 wrap.
REQ-038 Mode 2, seed 0 -> first stimulus 0001, second 0002; bench LFSR model matches 100 cycles.
REQ-039 Reset pulsed low at RUN cycle 4 of 8 -> all outputs at reset values same cycle, done_out never asserts; a new start then completes normally.
REQ-040 start_in held high throughout RUN -> no restart, cycle_count_out monotonic; start_in in DONE -> counters cleared, new run begins.
